// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-memory request/response plus the decode-side
// instruction handshake and resolved control-flow inputs.
interface fetch_unit_if;
    localparam int unsigned W_CPU    = 32;
    localparam int unsigned W_PC_SRC = 2;
    localparam int unsigned W_JADDR  = 26;
    localparam int unsigned W_IMM    = 16;

    logic                imem_req;
    logic [W_CPU-1:0]    imem_addr;
    logic                imem_ack;
    logic [W_CPU-1:0]    imem_rdata;
    logic [W_CPU-1:0]    inst;
    logic [W_CPU-1:0]    pc;
    logic [W_CPU-1:0]    pc_plus4;
    logic                inst_valid;
    logic                inst_ready;
    logic                redir_valid;
    logic [W_PC_SRC-1:0] pc_src;
    logic [W_JADDR-1:0]  jump_addr;
    logic [W_IMM-1:0]    br_imm;
    logic [W_CPU-1:0]    reg_target;
    logic                fetch_err;

    modport master (
        output imem_req, imem_addr, inst, pc, pc_plus4, inst_valid, fetch_err,
        input  imem_ack, imem_rdata, inst_ready, redir_valid, pc_src,
               jump_addr, br_imm, reg_target
    );

    modport slave (
        input  imem_req, imem_addr, inst, pc, pc_plus4, inst_valid, fetch_err,
        output imem_ack, imem_rdata, inst_ready, redir_valid, pc_src,
               jump_addr, br_imm, reg_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches words from instruction
// memory, presents them to decode and computes the next PC on accept.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int unsigned W_CPU = 32;
    localparam int unsigned W_CNT = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] PC_SRC_NEXT = 2'd0;
    localparam logic [1:0] PC_SRC_BRCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [1:0] PC_SRC_REGF = 2'd3;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [W_CNT-1:0] wait_cnt, wait_cnt_next;
    logic [W_CPU-1:0] fetch_pc, fetch_pc_next;
    logic [W_CPU-1:0] br_off;
    logic             load_inst;

    // Request address is the registered fetch PC, stable for the whole wait
    assign bus.imem_addr = fetch_pc;

    // State, wait counter and fetch PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RST;
            wait_cnt <= '0;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    // Next-state, wait counting and next-PC selection
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        fetch_pc_next = fetch_pc;
        load_inst     = 1'b0;
        br_off        = {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
        case (state)
            S_RST: begin
                // One idle cycle so a stale response from before reset is dropped
                state_next    = S_WAIT;
                fetch_pc_next = RESET_PC;
                wait_cnt_next = '0;
            end
            S_WAIT: begin
                if (bus.imem_ack) begin
                    load_inst     = 1'b1;
                    state_next    = S_HOLD;
                    wait_cnt_next = '0;
                end else if (wait_cnt == W_CNT'(MAX_WAIT - 1)) begin
                    state_next = S_ERR;
                end else begin
                    wait_cnt_next = wait_cnt + W_CNT'(1);
                end
            end
            S_HOLD: begin
                if (bus.inst_valid && bus.inst_ready) begin
                    state_next    = S_WAIT;
                    fetch_pc_next = bus.pc_plus4;
                    if (bus.redir_valid) begin
                        case (bus.pc_src)
                            PC_SRC_BRCH: fetch_pc_next = bus.pc_plus4 + br_off;
                            PC_SRC_JUMP: fetch_pc_next = {bus.pc_plus4[31:28], bus.jump_addr, 2'b00};
                            PC_SRC_REGF: begin
                                // Misaligned register target is fatal; never issue it
                                if (bus.reg_target[1:0] != 2'b00) begin
                                    state_next    = S_ERR;
                                    fetch_pc_next = fetch_pc;
                                end else begin
                                    fetch_pc_next = bus.reg_target;
                                end
                            end
                            PC_SRC_NEXT: fetch_pc_next = bus.pc_plus4;
                            default:     fetch_pc_next = bus.pc_plus4;
                        endcase
                    end
                end
            end
            S_ERR: state_next = S_ERR;
            default: state_next = S_RST;
        endcase
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.imem_req   <= 1'b0;
            bus.inst_valid <= 1'b0;
            bus.fetch_err  <= 1'b0;
            bus.inst       <= '0;
            bus.pc         <= RESET_PC;
            bus.pc_plus4   <= RESET_PC + 32'd4;
        end else begin
            bus.imem_req   <= (state_next == S_WAIT);
            bus.inst_valid <= (state_next == S_HOLD);
            bus.fetch_err  <= (state_next == S_ERR);
            if (load_inst) begin
                bus.inst     <= bus.imem_rdata;
                bus.pc       <= fetch_pc;
                bus.pc_plus4 <= fetch_pc + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized fetches
// against a transaction-level model of the fetch/redirect rules.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          MAX_WAIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_addr;
    bit          died;

    // Count one comparison and report it if it misses
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Next fetch address from the control-flow rules; bit 32 flags a fatal target
    function automatic logic [32:0] next_pc(input logic [31:0] cur, input logic rv,
                                            input logic [1:0] src, input logic [25:0] ja,
                                            input logic [15:0] bi, input logic [31:0] rt);
        logic [31:0] seq;
        logic [31:0] off;
        seq = cur + 32'd4;
        off = 32'($signed(bi));
        if (!rv) return {1'b0, seq};
        case (src)
            2'd1:    return {1'b0, seq + off * 32'd4};
            2'd2:    return {1'b0, (seq & 32'hF000_0000) | (32'(ja) * 32'd4)};
            2'd3:    return {(rt % 32'd4) != 32'd0, rt};
            default: return {1'b0, seq};
        endcase
    endfunction

    // Put junk on all inputs the DUT must ignore right now
    task automatic junk_inputs();
        bus.imem_ack    = 1'($urandom);
        bus.imem_rdata  = $urandom;
        bus.redir_valid = 1'($urandom);
        bus.pc_src      = 2'($urandom);
        bus.jump_addr   = 26'($urandom);
        bus.br_imm      = 16'($urandom);
        bus.reg_target  = $urandom;
    endtask

    // Reset with a stale ack pending; leaves the DUT in its first request cycle
    task automatic do_reset();
        @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.inst_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_req", bus.imem_req, 1'b0);
        check("rst_valid", bus.inst_valid, 1'b0);
        check("rst_err", bus.fetch_err, 1'b0);
        check("rst_pc", bus.pc, RESET_PC);
        check("rst_inst", bus.inst, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_idle_req", bus.imem_req, 1'b0);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("rst_stale_valid", bus.inst_valid, 1'b0);
        exp_addr = RESET_PC;
    endtask

    // One fetch transaction: d no-ack cycles, hold cycles before accept, then redirect
    task automatic fetch(input int d, input logic [31:0] data, input int hold,
                         input logic rv, input logic [1:0] src, input logic [25:0] ja,
                         input logic [15:0] bi, input logic [31:0] rt, output bit dead);
        logic [32:0] nxt;
        dead = 1'b0;
        check("req", bus.imem_req, 1'b1);
        check("addr", bus.imem_addr, exp_addr);
        check("addr_align", 32'(bus.imem_addr[1:0]), 32'h0);
        for (int k = 0; k < d; k++) begin
            bus.imem_ack = 1'b0;
            bus.inst_ready = 1'($urandom);
            @(negedge clk);
            if (k + 1 >= MAX_WAIT) begin
                check("timeout_err", bus.fetch_err, 1'b1);
                check("timeout_req", bus.imem_req, 1'b0);
                check("timeout_valid", bus.inst_valid, 1'b0);
                dead = 1'b1;
                return;
            end
            check("wait_req", bus.imem_req, 1'b1);
            check("wait_addr", bus.imem_addr, exp_addr);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        bus.inst_ready = 1'($urandom);
        @(negedge clk);
        check("valid", bus.inst_valid, 1'b1);
        check("inst", bus.inst, data);
        check("pc", bus.pc, exp_addr);
        check("pc_plus4", bus.pc_plus4, exp_addr + 32'd4);
        check("hold_req", bus.imem_req, 1'b0);
        for (int k = 0; k < hold; k++) begin
            junk_inputs();
            bus.inst_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", bus.inst_valid, 1'b1);
            check("hold_inst", bus.inst, data);
            check("hold_pc", bus.pc, exp_addr);
            check("hold_req", bus.imem_req, 1'b0);
        end
        bus.imem_ack    = 1'($urandom);
        bus.inst_ready  = 1'b1;
        bus.redir_valid = rv;
        bus.pc_src      = src;
        bus.jump_addr   = ja;
        bus.br_imm      = bi;
        bus.reg_target  = rt;
        nxt = next_pc(exp_addr, rv, src, ja, bi, rt);
        @(negedge clk);
        junk_inputs();
        bus.imem_ack   = 1'b0;
        bus.inst_ready = 1'b0;
        check("accept_valid", bus.inst_valid, 1'b0);
        if (nxt[32]) begin
            check("misalign_err", bus.fetch_err, 1'b1);
            for (int k = 0; k < 3; k++) begin
                bus.imem_ack = 1'b1;
                bus.inst_ready = 1'b1;
                @(negedge clk);
                check("err_req", bus.imem_req, 1'b0);
                check("err_valid", bus.inst_valid, 1'b0);
                check("err_sticky", bus.fetch_err, 1'b1);
            end
            bus.imem_ack = 1'b0;
            dead = 1'b1;
        end else begin
            check("next_req", bus.imem_req, 1'b1);
            check("next_addr", bus.imem_addr, nxt[31:0]);
            check("no_err", bus.fetch_err, 1'b0);
            exp_addr = nxt[31:0];
        end
    endtask

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;
        bus.redir_valid = 1'b0;
        bus.pc_src      = '0;
        bus.jump_addr   = '0;
        bus.br_imm      = '0;
        bus.reg_target  = '0;

        // Reset, zero-wait fetch, then a fetch held for 5 cycles
        do_reset();
        fetch(0, 32'h2408_0001, 0, 1'b0, 2'd0, '0, '0, '0, died);
        fetch(0, 32'h2409_0002, 5, 1'b0, 2'd0, '0, '0, '0, died);

        // Redirects from pc 0x00400010
        fetch(0, 32'h1111_1111, 0, 1'b1, 2'd3, '0, '0, 32'h0040_0010, died);
        fetch(1, 32'h2222_2222, 0, 1'b1, 2'd1, '0, 16'hFFFE, '0, died);
        fetch(0, 32'h1111_1111, 0, 1'b1, 2'd3, '0, '0, 32'h0040_0010, died);
        fetch(2, 32'h3333_3333, 1, 1'b1, 2'd2, 26'h010_0008, '0, '0, died);
        fetch(0, 32'h1111_1111, 0, 1'b1, 2'd3, '0, '0, 32'h0040_0010, died);
        fetch(0, 32'h4444_4444, 0, 1'b1, 2'd3, '0, '0, 32'h0040_0100, died);

        // Misaligned register target
        fetch(0, 32'h5555_5555, 0, 1'b1, 2'd3, '0, '0, 32'h0040_0102, died);
        do_reset();

        // Memory timeout, then an ack on the 7th request cycle
        fetch(MAX_WAIT, 32'h0, 0, 1'b0, 2'd0, '0, '0, '0, died);
        do_reset();
        fetch(6, 32'h6666_6666, 0, 1'b0, 2'd0, '0, '0, '0, died);

        // Reset while waiting, then wraparound of the PC
        do_reset();
        fetch(0, 32'h7777_7777, 0, 1'b1, 2'd3, '0, '0, 32'hFFFF_FFFC, died);
        fetch(0, 32'h8888_8888, 0, 1'b0, 2'd0, '0, '0, '0, died);
        check("wrap_addr", bus.imem_addr, 32'h0);

        // Randomized fetch stream
        for (int i = 0; i < 300; i++) begin
            int          d;
            logic [31:0] rt;
            d  = ($urandom_range(0, 19) == 0) ? MAX_WAIT + int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, MAX_WAIT - 1));
            rt = $urandom;
            if ($urandom_range(0, 9) != 0) rt[1:0] = 2'b00;
            fetch(d, $urandom, int'($urandom_range(0, 3)), 1'($urandom), 2'($urandom),
                  26'($urandom), 16'($urandom), rt, died);
            if (died) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
